// File: rtl/pipe_pkg.sv
// Shared defaults and helpers for the elastic pipeline-register chain.
// Holds default payload width/depth and the occupancy popcount.
package pipe_pkg;

  localparam int PIPE_WIDTH_DEF = 8;
  localparam int PIPE_DEPTH_DEF = 4;

  // Widest valid vector the popcount helper handles.
  localparam int PIPE_MAX_DEPTH = 32;
  localparam int PIPE_CNT_W     = $clog2(PIPE_MAX_DEPTH + 1);

  function automatic logic [PIPE_CNT_W-1:0] popcount(
    input logic [PIPE_MAX_DEPTH-1:0] vec
  );
    logic [PIPE_CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < PIPE_MAX_DEPTH; i++) begin
      c = c + PIPE_CNT_W'(vec[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid/data register pair.
// Ports: load_i (slot takes src), src_v_i/src_d_i (incoming item),
//   kill_i/flush_i (drop held item), v_o/d_o (state), v_d_o (next valid).
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             src_v_i,
  input  logic [WIDTH-1:0] src_d_i,
  input  logic             kill_i,
  input  logic             flush_i,
  output logic             v_o,
  output logic             v_d_o,
  output logic [WIDTH-1:0] d_o
);

  logic             v_q;
  logic             v_d;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] d_d;
  logic             d_en;

  // A loading slot takes whatever arrives (possibly a bubble); a holding
  // slot keeps its item unless it is killed or flushed. Data only moves
  // when a live item arrives, so bubbles never toggle the data register.
  always_comb begin
    v_d  = v_q & ~kill_i & ~flush_i;
    d_en = 1'b0;
    d_d  = src_d_i;
    if (load_i) begin
      v_d  = src_v_i;
      d_en = src_v_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      if (d_en) begin
        d_q <= d_d;
      end
    end
  end

  assign v_o   = v_q;
  assign v_d_o = v_d;
  assign d_o   = d_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic valid/ready register chain with flush, per-slot kill, occupancy.
// Ports: in_* upstream handshake, out_* downstream, flush, kill[DEPTH],
//   slot_valid (per-slot valid), count (registered occupancy).
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter  int WIDTH = PIPE_WIDTH_DEF,
  parameter  int DEPTH = PIPE_DEPTH_DEF,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  input  logic [DEPTH-1:0] kill,
  output logic [DEPTH-1:0] slot_valid,
  output logic [CW-1:0]    count
);

  logic [DEPTH:0]      rdy;
  logic [DEPTH-1:0]    v_q;
  logic [DEPTH-1:0]    v_d;
  logic [DEPTH-1:0]    src_v;
  logic [WIDTH-1:0]    src_d [DEPTH];
  logic [WIDTH-1:0]    d_q   [DEPTH];
  logic                accept;
  logic [CW-1:0]       count_q;
  logic [CW-1:0]       count_d;
  logic [PIPE_MAX_DEPTH-1:0] v_pad;

  // Ready ripples from the output back to the input: an empty slot
  // always accepts, so gaps collapse while downstream flows.
  always_comb begin
    rdy[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rdy[k] = ~v_q[k] | rdy[k+1];
    end
  end

  assign in_ready = rdy[0] & ~flush;
  assign accept   = in_valid & in_ready;

  // Items leaving a slot are filtered by that slot's kill and by flush.
  always_comb begin
    src_v[0] = accept;
    src_d[0] = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      src_v[k] = v_q[k-1] & ~kill[k-1] & ~flush;
      src_d[k] = d_q[k-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    pipe_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk     (clk),
      .reset   (reset),
      .load_i  (rdy[g]),
      .src_v_i (src_v[g]),
      .src_d_i (src_d[g]),
      .kill_i  (kill[g]),
      .flush_i (flush),
      .v_o     (v_q[g]),
      .v_d_o   (v_d[g]),
      .d_o     (d_q[g])
    );
  end

  assign out_valid  = v_q[DEPTH-1] & ~kill[DEPTH-1] & ~flush;
  assign out_data   = out_valid ? d_q[DEPTH-1] : '0;
  assign slot_valid = v_q;

  assign v_pad   = PIPE_MAX_DEPTH'(v_d);
  assign count_d = CW'(popcount(v_pad));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (WIDTH=8, DEPTH=4).
// Inputs change #1 after rising edges; outputs checked there too.
module tb_pipe_stage_chain;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       flush;
  logic [3:0] kill;
  logic [3:0] slot_valid;
  logic [2:0] count;

  int checks;
  int failures;

  pipe_stage_chain #(
    .WIDTH (8),
    .DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .flush      (flush),
    .kill       (kill),
    .slot_valid (slot_valid),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    flush     = 1'b0;
    kill      = 4'b0000;
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_ovalid", 32'(out_valid), 0);
    chk("rst_odata", 32'(out_data), 0);
    chk("rst_slotv", 32'(slot_valid), 0);
    reset = 1'b0;
    #1;
    chk("rst_inready", 32'(in_ready), 1);
    flush = 1'b1;
    #1;
    chk("flush_inready", 32'(in_ready), 0);
    flush = 1'b0;
    tick();

    // Fill with out_ready high
    out_ready = 1'b1;
    push(8'h11);
    chk("fill_c1", 32'(count), 1);
    push(8'h22);
    chk("fill_c2", 32'(count), 2);
    push(8'h33);
    chk("fill_c3", 32'(count), 3);
    in_valid = 1'b0;
    chk("fill_ov0", 32'(out_valid), 0);
    tick();
    chk("fill_ov1", 32'(out_valid), 1);
    chk("fill_d11", 32'(out_data), 32'h11);
    chk("fill_c3b", 32'(count), 3);
    tick();
    chk("fill_d22", 32'(out_data), 32'h22);
    chk("fill_c2b", 32'(count), 2);
    tick();
    chk("fill_d33", 32'(out_data), 32'h33);
    chk("fill_c1b", 32'(count), 1);
    tick();
    chk("fill_empty", 32'(out_valid), 0);
    chk("fill_c0", 32'(count), 0);

    // Backpressure
    out_ready = 1'b0;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    chk("bp_inready3", 32'(in_ready), 1);
    push(8'h04);
    chk("bp_count4", 32'(count), 4);
    chk("bp_inready0", 32'(in_ready), 0);
    chk("bp_d01", 32'(out_data), 32'h01);
    push(8'h05);
    push(8'h05);
    chk("bp_hold_c", 32'(count), 4);
    chk("bp_hold_d", 32'(out_data), 32'h01);
    out_ready = 1'b1;
    #1;
    chk("bp_inready_r", 32'(in_ready), 1);
    push(8'h05);
    chk("bp_pop2", 32'(out_data), 32'h02);
    chk("bp_full_c", 32'(count), 4);
    push(8'h06);
    chk("bp_pop3", 32'(out_data), 32'h03);
    in_valid = 1'b0;
    tick();
    chk("bp_pop4", 32'(out_data), 32'h04);
    tick();
    chk("bp_pop5", 32'(out_data), 32'h05);
    tick();
    chk("bp_pop6", 32'(out_data), 32'h06);
    chk("bp_c1", 32'(count), 1);
    tick();
    chk("bp_done", 32'(out_valid), 0);
    chk("bp_c0", 32'(count), 0);

    // Kill squash: slot0..3 = A0..A3
    out_ready = 1'b0;
    push(8'hA3);
    push(8'hA2);
    push(8'hA1);
    push(8'hA0);
    in_valid = 1'b0;
    chk("kill_full", 32'(count), 4);
    kill = 4'b0110;
    out_ready = 1'b1;
    #1;
    chk("kill_ov", 32'(out_valid), 1);
    chk("kill_dA3", 32'(out_data), 32'hA3);
    tick();
    kill = 4'b0000;
    chk("kill_c1", 32'(count), 1);
    chk("kill_slotv", 32'(slot_valid), 32'h2);
    chk("kill_ov0", 32'(out_valid), 0);
    tick();
    chk("kill_ov0b", 32'(out_valid), 0);
    tick();
    chk("kill_dA0", 32'(out_data), 32'hA0);
    tick();
    chk("kill_empty", 32'(count), 0);

    // Output-slot kill hides the item
    out_ready = 1'b0;
    push(8'h5A);
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("okill_pre", 32'(out_data), 32'h5A);
    kill = 4'b1000;
    #1;
    chk("okill_ov", 32'(out_valid), 0);
    chk("okill_od", 32'(out_data), 0);
    tick();
    kill = 4'b0000;
    chk("okill_c0", 32'(count), 0);

    // Flush during stall
    push(8'hB0);
    push(8'hB1);
    push(8'hB2);
    push(8'hB3);
    chk("fl_full", 32'(count), 4);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    #1;
    chk("fl_inready", 32'(in_ready), 0);
    chk("fl_ov", 32'(out_valid), 0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_c0", 32'(count), 0);
    chk("fl_slotv", 32'(slot_valid), 0);
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    tick();
    chk("fl_noff", 32'(out_valid), 0);
    chk("fl_c0b", 32'(count), 0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    push(8'hC1);
    push(8'hC2);
    push(8'hC3);
    in_valid = 1'b0;
    tick();
    chk("ar_c3", 32'(count), 3);
    chk("ar_dC1", 32'(out_data), 32'hC1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_slotv", 32'(slot_valid), 0);
    chk("ar_od", 32'(out_data), 0);
    chk("ar_ov", 32'(out_valid), 0);
    chk("ar_c0", 32'(count), 0);
    reset = 1'b0;
    tick();

    // Bubble collapse with out_ready 1,0,1
    out_ready = 1'b1;
    push(8'hD1);
    chk("bc_c1", 32'(count), 1);
    in_valid = 1'b0;
    tick();
    chk("bc_sv1", 32'(slot_valid), 32'h2);
    out_ready = 1'b0;
    push(8'hD2);
    chk("bc_sv2", 32'(slot_valid), 32'h5);
    chk("bc_c2", 32'(count), 2);
    out_ready = 1'b1;
    push(8'hD3);
    chk("bc_sv3", 32'(slot_valid), 32'hB);
    chk("bc_c3", 32'(count), 3);
    chk("bc_dD1", 32'(out_data), 32'hD1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    chk("bc_sv4", 32'(slot_valid), 32'hE);
    chk("bc_hold", 32'(out_data), 32'hD1);
    out_ready = 1'b1;
    tick();
    chk("bc_dD2", 32'(out_data), 32'hD2);
    chk("bc_c2b", 32'(count), 2);
    tick();
    chk("bc_dD3", 32'(out_data), 32'hD3);
    chk("bc_c1", 32'(count), 1);
    tick();
    chk("bc_c0", 32'(count), 0);
    chk("bc_ov0", 32'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
